// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit.
//   - fetch_state_e : FSM encoding (FETCH / FULL_HOLD / MISS_REDIRECT)
//   - fq_entry_t    : one prefetch queue entry {pc, instr}
//   - XLEN, PC_INC  : instruction word width and sequential PC step
//   - align_pc()    : forces a target address onto a word boundary
package fetch_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] PC_INC = 32'd4;

  typedef enum logic [1:0] {
    FETCH         = 2'd0,
    FULL_HOLD     = 2'd1,
    MISS_REDIRECT = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fq_entry_t;

  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Bus bundle around the fetch unit: cache side (pc/instr/stall), redirect
// input from later stages, decode-side valid/ready queue head, and the
// stall statistics counter.
//   master : the fetch unit itself
//   slave  : its environment (cache + decode + redirect source)
interface instr_fetch_unit_if;
  import fetch_pkg::*;

  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] instr;
  logic            stall;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            fq_valid;
  logic [XLEN-1:0] fq_instr;
  logic [XLEN-1:0] fq_pc;
  logic            fq_ready;
  logic [XLEN-1:0] stall_cycles;

  modport master (
    output pc, fq_valid, fq_instr, fq_pc, stall_cycles,
    input  instr, stall, redirect_valid, redirect_pc, fq_ready
  );

  modport slave (
    input  pc, fq_valid, fq_instr, fq_pc, stall_cycles,
    output instr, stall, redirect_valid, redirect_pc, fq_ready
  );

endinterface

// File: rtl/instr_fetch_unit_fetch_queue.sv
// fetch_queue: DEPTH-entry FIFO of {pc, instr} entries.
//   clk, rst   : clock, synchronous active-high reset (clears storage too)
//   push, pop  : enqueue wr_data / dequeue head (ignored when not possible)
//   flush      : empties the queue, wins over push and pop
//   wr_data    : entry to enqueue
//   head       : entry at the read pointer (stable while empty)
//   count      : occupancy 0..DEPTH
//   full/empty : occupancy flags
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           push,
  input  logic           pop,
  input  logic           flush,
  input  fq_entry_t      wr_data,
  output fq_entry_t      head,
  output logic [PTR_W:0] count,
  output logic           full,
  output logic           empty
);

  localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W+1)'(DEPTH);

  fq_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W:0]   count_reg;
  logic             pop_ok;
  logic             push_ok;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == DEPTH_CNT);
  assign pop_ok  = pop & ~empty;
  // A full queue may still accept a push when the head leaves the same cycle.
  assign push_ok = push & (~full | pop_ok);

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_reg <= count_reg + (PTR_W+1)'(1);
        2'b01:   count_reg <= count_reg - (PTR_W+1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Storage is cleared on reset so the head reads as zero afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push_ok && !flush) begin
      mem[wr_ptr_reg] <= wr_data;
    end
  end

  assign head  = mem[rd_ptr_reg];
  assign count = count_reg;

endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: fetch-side initiator for the instruction cache.
//   clk, rst : clock, synchronous active-high reset
//   bus      : instr_fetch_unit_if.master
//              pc out / instr, stall in          (cache)
//              redirect_valid, redirect_pc in     (later stages)
//              fq_valid, fq_instr, fq_pc out / fq_ready in (decode)
//              stall_cycles out                   (saturating miss-cycle count)
// Holds the fetch FSM, PC register, pending redirect target and stall counter;
// fetched words are buffered in fetch_queue.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4,
  parameter int          PTR_W    = 2
) (
  input logic               clk,
  input logic               rst,
  instr_fetch_unit_if.master bus
);

  localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W+1)'(DEPTH);

  fetch_state_e    state_reg, state_next;
  logic [XLEN-1:0] pc_reg, pc_next;
  logic [XLEN-1:0] target_reg, target_next;
  logic [XLEN-1:0] stall_cnt_reg;

  logic            push, flush, pop, space;
  logic [PTR_W:0]  q_count;
  logic            q_full, q_empty;
  fq_entry_t       q_head, wr_entry;

  assign pop      = ~q_empty & bus.fq_ready;
  assign space    = (q_count < DEPTH_CNT) | pop;
  assign wr_entry = '{pc: pc_reg, instr: bus.instr};

  fetch_queue #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_queue (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .pop     (pop),
    .flush   (flush),
    .wr_data (wr_entry),
    .head    (q_head),
    .count   (q_count),
    .full    (q_full),
    .empty   (q_empty)
  );

  always_comb begin
    state_next  = state_reg;
    pc_next     = pc_reg;
    target_next = target_reg;
    push        = 1'b0;
    flush       = 1'b0;
    if (bus.redirect_valid) begin
      flush = 1'b1;
      if (bus.stall) begin
        // Keep pc stable for the refill; apply the target once the miss ends.
        target_next = align_pc(bus.redirect_pc);
        state_next  = MISS_REDIRECT;
      end else begin
        pc_next    = align_pc(bus.redirect_pc);
        state_next = FETCH;
      end
    end else begin
      case (state_reg)
        FETCH: begin
          if (!bus.stall) begin
            if (space) begin
              push    = 1'b1;
              pc_next = pc_reg + PC_INC;
            end else begin
              state_next = FULL_HOLD;
            end
          end
        end
        FULL_HOLD: begin
          // Leave without pushing; the held pc is re-fetched next cycle.
          if (!q_full || pop) state_next = FETCH;
        end
        MISS_REDIRECT: begin
          // The word returned for the stale pc is dropped.
          if (!bus.stall) begin
            pc_next    = target_reg;
            state_next = FETCH;
          end
        end
        default: state_next = FETCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= FETCH;
      pc_reg        <= RESET_PC;
      target_reg    <= '0;
      stall_cnt_reg <= '0;
    end else begin
      state_reg  <= state_next;
      pc_reg     <= pc_next;
      target_reg <= target_next;
      if (bus.stall && stall_cnt_reg != '1) stall_cnt_reg <= stall_cnt_reg + 32'd1;
    end
  end

  assign bus.pc           = pc_reg;
  assign bus.fq_valid     = ~q_empty;
  assign bus.fq_instr     = q_head.instr;
  assign bus.fq_pc        = q_head.pc;
  assign bus.stall_cycles = stall_cnt_reg;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios plus a
// randomized run compared against a queue-based reference model.
module tb_instr_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] instr_key = 32'hA5A5_0000;
  int          total = 0;
  int          bad   = 0;

  instr_fetch_unit_if bus ();

  // Cache model: answers combinationally for the current pc.
  assign bus.instr = bus.pc ^ instr_key;

  instr_fetch_unit #(
    .RESET_PC (RESET_PC),
    .DEPTH    (DEPTH),
    .PTR_W    (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [63:0] m_q[$];
  logic [31:0] m_pc;
  logic [31:0] m_target;
  logic [31:0] m_sc;
  bit          m_hold;
  bit          m_miss;

  task automatic model_edge();
    bit pop_now, has_room, do_fetch;
    if (rst) begin
      m_q.delete();
      m_pc = RESET_PC; m_target = '0; m_sc = '0; m_hold = 0; m_miss = 0;
      return;
    end
    pop_now  = (m_q.size() != 0) && bus.fq_ready;
    has_room = (m_q.size() < DEPTH) || pop_now;
    if (bus.stall && m_sc != 32'hFFFF_FFFF) m_sc = m_sc + 1;
    if (bus.redirect_valid) begin
      m_q.delete();
      m_hold = 0;
      if (bus.stall) begin
        m_target = {bus.redirect_pc[31:2], 2'b00};
        m_miss   = 1;
      end else begin
        m_pc   = {bus.redirect_pc[31:2], 2'b00};
        m_miss = 0;
      end
    end else if (m_miss) begin
      if (!bus.stall) begin
        m_pc   = m_target;
        m_miss = 0;
      end
    end else begin
      do_fetch = !m_hold && !bus.stall && has_room;
      if (m_hold) begin
        if (has_room) m_hold = 0;
      end else if (!bus.stall && !has_room) begin
        m_hold = 1;
      end
      if (pop_now) void'(m_q.pop_front());
      if (do_fetch) begin
        m_q.push_back({m_pc, m_pc ^ instr_key});
        m_pc = m_pc + 32'd4;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.stall = 1'b0; bus.redirect_valid = 1'b0;
    bus.redirect_pc = '0; bus.fq_ready = 1'b0;
    step(); step();
    rst = 1'b0;
    total++; if (bus.pc !== RESET_PC) begin bad++; $display("FAIL reset_pc got=%h exp=%h", bus.pc, RESET_PC); end
    total++; if (bus.fq_valid !== 1'b0) begin bad++; $display("FAIL reset_fq_valid got=%b exp=0", bus.fq_valid); end
    total++; if (bus.fq_pc !== 32'h0) begin bad++; $display("FAIL reset_fq_pc got=%h exp=0", bus.fq_pc); end
    total++; if (bus.fq_instr !== 32'h0) begin bad++; $display("FAIL reset_fq_instr got=%h exp=0", bus.fq_instr); end
    total++; if (bus.stall_cycles !== 32'h0) begin bad++; $display("FAIL reset_stall_cycles got=%0d exp=0", bus.stall_cycles); end
    $display("test_reset checked");
  endtask

  task automatic test_stream();
    logic [31:0] exp_pc;
    apply_reset();
    instr_key = 32'hA5A5_0000; bus.stall = 1'b0; bus.fq_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      exp_pc = 32'(i * 4);
      total++; if (bus.fq_valid !== 1'b1 || bus.fq_pc !== exp_pc) begin
        bad++; $display("FAIL stream_fq_pc i=%0d got=%h/%b exp=%h/1", i, bus.fq_pc, bus.fq_valid, exp_pc); end
      total++; if (bus.fq_instr !== (exp_pc ^ 32'hA5A5_0000)) begin
        bad++; $display("FAIL stream_fq_instr i=%0d got=%h exp=%h", i, bus.fq_instr, exp_pc ^ 32'hA5A5_0000); end
      $display("stream xfer pc=%h instr=%h", bus.fq_pc, bus.fq_instr);
    end
    total++; if (bus.stall_cycles !== 32'h0) begin bad++; $display("FAIL stream_stall_cycles got=%0d exp=0", bus.stall_cycles); end
  endtask

  task automatic test_full_hold();
    logic [31:0] exp_pc;
    apply_reset();
    bus.stall = 1'b0; bus.fq_ready = 1'b0;
    repeat (6) step();
    total++; if (bus.pc !== 32'd16) begin bad++; $display("FAIL full_pc_hold got=%h exp=10", bus.pc); end
    total++; if (bus.fq_pc !== 32'd0) begin bad++; $display("FAIL full_head got=%h exp=0", bus.fq_pc); end
    bus.fq_ready = 1'b1;
    step();
    bus.fq_ready = 1'b0;
    total++; if (bus.fq_pc !== 32'd4 || bus.pc !== 32'd16) begin
      bad++; $display("FAIL full_pop head=%h pc=%h exp head=4 pc=10", bus.fq_pc, bus.pc); end
    step();
    total++; if (bus.pc !== 32'd20) begin bad++; $display("FAIL full_refetch got=%h exp=14", bus.pc); end
    step();
    total++; if (bus.pc !== 32'd20) begin bad++; $display("FAIL full_rehold got=%h exp=14", bus.pc); end
    bus.fq_ready = 1'b1;
    exp_pc = 32'd4;
    for (int i = 0; i < 8; i++) begin
      total++; if (bus.fq_valid !== 1'b1 || bus.fq_pc !== exp_pc) begin
        bad++; $display("FAIL full_order i=%0d got=%h/%b exp=%h/1", i, bus.fq_pc, bus.fq_valid, exp_pc); end
      $display("full xfer pc=%h", bus.fq_pc);
      step();
      exp_pc = exp_pc + 32'd4;
    end
  endtask

  task automatic test_stall();
    apply_reset();
    bus.stall = 1'b0; bus.fq_ready = 1'b1;
    repeat (8) step();
    total++; if (bus.pc !== 32'd32) begin bad++; $display("FAIL stall_setup_pc got=%h exp=20", bus.pc); end
    bus.stall = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      total++; if (bus.pc !== 32'd32) begin bad++; $display("FAIL stall_pc i=%0d got=%h exp=20", i, bus.pc); end
    end
    total++; if (bus.stall_cycles !== 32'd10) begin bad++; $display("FAIL stall_count got=%0d exp=10", bus.stall_cycles); end
    total++; if (bus.fq_valid !== 1'b0) begin bad++; $display("FAIL stall_no_push got=%b exp=0", bus.fq_valid); end
    bus.stall = 1'b0;
    step();
    total++; if (bus.fq_valid !== 1'b1 || bus.fq_pc !== 32'd32 || bus.fq_instr !== (32'd32 ^ instr_key)) begin
      bad++; $display("FAIL stall_resume got=%h/%h/%b exp=20/%h/1", bus.fq_pc, bus.fq_instr, bus.fq_valid, 32'd32 ^ instr_key); end
    total++; if (bus.pc !== 32'd36) begin bad++; $display("FAIL stall_resume_pc got=%h exp=24", bus.pc); end
  endtask

  task automatic test_redirect();
    apply_reset();
    bus.stall = 1'b0; bus.fq_ready = 1'b0;
    repeat (3) step();
    bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h0000_0103;
    step();
    bus.redirect_valid = 1'b0;
    total++; if (bus.fq_valid !== 1'b0) begin bad++; $display("FAIL redir_flush got=%b exp=0", bus.fq_valid); end
    total++; if (bus.pc !== 32'h100) begin bad++; $display("FAIL redir_pc got=%h exp=100", bus.pc); end
    step();
    total++; if (bus.fq_valid !== 1'b1 || bus.fq_pc !== 32'h100 || bus.fq_instr !== (32'h100 ^ instr_key)) begin
      bad++; $display("FAIL redir_first got=%h/%h/%b exp=100/%h/1", bus.fq_pc, bus.fq_instr, bus.fq_valid, 32'h100 ^ instr_key); end
  endtask

  task automatic test_miss_redirect();
    apply_reset();
    bus.stall = 1'b0; bus.fq_ready = 1'b0;
    repeat (2) step();
    bus.stall = 1'b1; bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h200;
    step();
    bus.redirect_valid = 1'b0;
    total++; if (bus.pc !== 32'd8 || bus.fq_valid !== 1'b0) begin
      bad++; $display("FAIL miss_redir_hold pc=%h v=%b exp pc=8 v=0", bus.pc, bus.fq_valid); end
    step();
    bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h300;
    step();
    bus.redirect_valid = 1'b0;
    step();
    total++; if (bus.pc !== 32'd8) begin bad++; $display("FAIL miss_redir_pc_stable got=%h exp=8", bus.pc); end
    bus.stall = 1'b0;
    step();
    total++; if (bus.pc !== 32'h300 || bus.fq_valid !== 1'b0) begin
      bad++; $display("FAIL miss_redir_apply pc=%h v=%b exp pc=300 v=0", bus.pc, bus.fq_valid); end
    step();
    total++; if (bus.fq_valid !== 1'b1 || bus.fq_pc !== 32'h300 || bus.pc !== 32'h304) begin
      bad++; $display("FAIL miss_redir_first head=%h v=%b pc=%h exp 300/1/304", bus.fq_pc, bus.fq_valid, bus.pc); end
  endtask

  task automatic test_reset_mid_miss();
    apply_reset();
    bus.stall = 1'b0; bus.fq_ready = 1'b0;
    repeat (6) step();
    bus.stall = 1'b1;
    repeat (3) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    total++; if (bus.pc !== RESET_PC || bus.fq_valid !== 1'b0) begin
      bad++; $display("FAIL rst_miss pc=%h v=%b exp pc=%h v=0", bus.pc, bus.fq_valid, RESET_PC); end
    total++; if (bus.stall_cycles !== 32'd0 || bus.fq_pc !== 32'd0 || bus.fq_instr !== 32'd0) begin
      bad++; $display("FAIL rst_miss_clear sc=%0d fq_pc=%h fq_instr=%h exp 0/0/0", bus.stall_cycles, bus.fq_pc, bus.fq_instr); end
    bus.stall = 1'b0;
    step();
    total++; if (bus.pc !== RESET_PC + 32'd4 || bus.fq_valid !== 1'b1 || bus.fq_pc !== RESET_PC) begin
      bad++; $display("FAIL rst_miss_fetch pc=%h head=%h v=%b exp pc=%h head=%h v=1", bus.pc, bus.fq_pc, bus.fq_valid, RESET_PC + 32'd4, RESET_PC); end
  endtask

  task automatic test_random();
    logic [63:0] head;
    apply_reset();
    for (int i = 0; i < 600; i++) begin
      bus.stall          = ($urandom_range(0, 3) == 0);
      bus.redirect_valid = ($urandom_range(0, 19) == 0);
      bus.redirect_pc    = $urandom;
      bus.fq_ready       = ($urandom_range(0, 2) != 0);
      rst                = ($urandom_range(0, 99) == 0);
      instr_key          = $urandom;
      if (bus.fq_valid && bus.fq_ready && !rst)
        $display("rand xfer cyc=%0d pc=%h instr=%h", i, bus.fq_pc, bus.fq_instr);
      step();
      rst = 1'b0;
      total++; if (bus.pc !== m_pc) begin bad++; $display("FAIL rand_pc cyc=%0d got=%h exp=%h", i, bus.pc, m_pc); end
      total++; if (bus.fq_valid !== (m_q.size() != 0)) begin
        bad++; $display("FAIL rand_fq_valid cyc=%0d got=%b exp=%b", i, bus.fq_valid, m_q.size() != 0); end
      total++; if (bus.stall_cycles !== m_sc) begin
        bad++; $display("FAIL rand_stall_cycles cyc=%0d got=%0d exp=%0d", i, bus.stall_cycles, m_sc); end
      if (m_q.size() != 0) begin
        head = m_q[0];
        total++; if ({bus.fq_pc, bus.fq_instr} !== head) begin
          bad++; $display("FAIL rand_head cyc=%0d got=%h_%h exp=%h", i, bus.fq_pc, bus.fq_instr, head); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_full_hold();
    test_stall();
    test_redirect();
    test_miss_redirect();
    test_reset_mid_miss();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Fetch-side initiator for the instruction cache top module.
- Drives `pc` into the cache, honours `stall`, and captures each returned `instr` into a small prefetch queue.
- Presents queued instructions to decode over a valid/ready handshake.
- Handles branch/jump redirects from later stages, including a redirect that arrives during a cache miss.

Parameters:
- RESET_PC, 32'h0000_0000, PC driven after reset; bits [1:0] must be 0.
- DEPTH, 4, prefetch queue entries; power of two, at least 2.
- PTR_W, 2, log2(DEPTH).

Ports:
- clk, input, 1, single clock; all state updates on the rising edge.
- rst, input, 1, synchronous reset, active-high.
- pc, output, 32, fetch address to the cache.
- instr, input, 32, cache read data for the current `pc`; valid when `stall`=0.
- stall, input, 1, cache miss/refill in progress; `instr` is not valid.
- redirect_valid, input, 1, one-cycle pulse requesting a fetch redirect.
- redirect_pc, input, 32, redirect target; bits [1:0] are ignored and forced to 0.
- fq_valid, output, 1, queue head is valid.
- fq_instr, output, 32, instruction at the queue head.
- fq_pc, output, 32, PC of the queue head instruction.
- fq_ready, input, 1, decode accepts the head this cycle.
- stall_cycles, output, 32, saturating count of cycles with `stall`=1 since reset.

Behaviour:
- Cache contract:
  - `pc` is registered. The cache answers combinationally in the same cycle.
  - A fetch completes on any rising edge where `stall`=0 and the FSM is in FETCH.
- Reset (rst=1 at an edge):
  - pc=RESET_PC; queue emptied, so fq_valid=0.
  - fq_instr=0, fq_pc=0 (head storage cleared); stall_cycles=0.
  - FSM=FETCH; pending target cleared.
  - Reset has priority over every other input, including mid-miss and mid-redirect.
- Derived signals:
  - pop = fq_valid & fq_ready.
  - space = (count<DEPTH) | pop.
- FSM states FETCH, FULL_HOLD, MISS_REDIRECT.
- FETCH:
  - stall=0 & space & !redirect_valid: push {pc, instr}; pc <= pc+4 (mod 2^32).
  - stall=0 & !space & !redirect_valid: no push; pc held; go FULL_HOLD.
  - stall=1 & !redirect_valid: pc held; no push.
- FULL_HOLD:
  - pc held; no push.
  - Return to FETCH on the first edge where count<DEPTH, or on an edge with pop=1. Do not push on that edge; the re-fetch of `pc` happens in the next cycle.
- Redirect, any state:
  - stall=0 at the redirect edge: flush queue (count=0, pointers 0); drop the current `instr`; pc <= {redirect_pc[31:2],2'b00}; FSM=FETCH.
  - stall=1 at the redirect edge: flush queue; latch the target; FSM=MISS_REDIRECT; `pc` stays unchanged so the cache sees a stable address during refill.
- MISS_REDIRECT:
  - While stall=1: hold.
  - First edge with stall=0: discard `instr`; pc <= latched target; FSM=FETCH.
  - A new redirect_valid here overwrites the latched target (youngest wins).
  - The queue stays empty throughout.
- Simultaneous events:
  - redirect + pop on the same edge: flush wins; count=0.
  - push + pop on the same edge: count unchanged; head advances.
- Queue ordering: strict FIFO. fq_instr/fq_pc are driven from the head entry; they are undefined-but-stable when fq_valid=0. Pointers wrap modulo DEPTH.
- stall_cycles: increments on every edge with stall=1; saturates at 32'hFFFF_FFFF.
- Latency: an instruction fetched at edge N is visible on fq_valid after edge N (one cycle).

Decomposition:
- Package `fetch_pkg`:
  - FSM state encoding (FETCH=2'd0, FULL_HOLD=2'd1, MISS_REDIRECT=2'd2).
  - PC_INC=32'd4.
  - Instruction-word width constant 32.
- Sub-module `fetch_queue`: DEPTH-entry FIFO of 64-bit {pc, instr}, with push, pop, flush, count, full, empty.
- `instr_fetch_unit` holds the FSM, PC register, pending-target register and stall counter.

Test Plan:
- Reset, then hold stall=0, fq_ready=1 with cache returning instr=pc^32'hA5A5_0000 → fq_pc sequence 0,4,8,12 on consecutive cycles, matching fq_instr; stall_cycles=0.
- fq_ready=0 with stall=0 → after 4 pushes (pc=0..12) pc holds at 16 and FSM=FULL_HOLD. Raise fq_ready for one cycle → fq_pc=0 pops; next cycle pc 16 is fetched; no entry is lost or duplicated.
- stall=1 for 10 cycles at pc=32 → pc stays 32; no push; stall_cycles=10. Then stall=0 → entry 32 is pushed.
- Redirect to 32'h0000_0103 with stall=0 and 3 entries queued → fq_valid=0 the next cycle; pc=32'h100; next pushed fq_pc=32'h100.
- Redirect to 32'h200 during stall=1, then a second redirect to 32'h300 before stall drops → pc unchanged until stall falls; the instr returned then is dropped; pc=32'h300; first queued fq_pc=32'h300.
- Assert rst mid-miss with the queue full → next cycle pc=RESET_PC, fq_valid=0, FSM=FETCH, stall_cycles=0.
